// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the unified-memory port arbiter and its response
// tag pipe: requester owner codes, the response tag record, the maximum
// supported RAM read latency, the byte-enable width and an address helper.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam logic ARB_OWN_IF  = 1'b0;
    localparam logic ARB_OWN_D   = 1'b1;
    localparam int   MEM_LAT_MAX = 4;
    localparam int   BE_W        = 4;

    // One entry of the response pipe: a read is in flight and who owns it.
    typedef struct packed {
        logic vld;
        logic own;
    } resp_tag_t;

    // Rebuild a word-aligned byte address from its word index.
    function automatic logic [31:0] word_align(input logic [29:0] word_idx);
        return {word_idx, 2'b00};
    endfunction

endpackage

// File: rtl/mem_resp_tag_pipe.sv
// -----------------------------------------------------------------------------
// mem_resp_tag_pipe
// DEPTH-stage shift register carrying {vld, owner} for every read issued to
// the RAM, so that the tag leaves the pipe in the same cycle the RAM presents
// the matching read data. Responses therefore come back in issue order.
//
// Ports
//   clk       in  1  core clock
//   rst       in  1  asynchronous active-low reset; clears every stage
//   push_vld  in  1  a read was granted this cycle
//   push_own  in  1  owner of that read (ARB_OWN_IF / ARB_OWN_D)
//   pop_vld   out 1  read data for the oldest read is on the RAM bus now
//   pop_own   out 1  owner of that read
// -----------------------------------------------------------------------------
module mem_resp_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic push_vld,
    input  logic push_own,
    output logic pop_vld,
    output logic pop_own
);

    resp_tag_t tag_p [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_p[i] <= '0;
            end
        end else begin
            tag_p[0] <= '{vld: push_vld, own: push_own};
            for (int i = 1; i < DEPTH; i++) begin
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    assign pop_vld = tag_p[DEPTH-1].vld;
    assign pop_own = tag_p[DEPTH-1].own;

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported synchronous RAM between instruction fetch (IF) and
// the data load/store path. One requester is granted per cycle (data has
// strict priority), the winner drives the RAM in the same cycle, and read
// data is routed back to its owner MEM_LAT cycles later.
//
// Optional feature: define ARB_STARVE_GUARD_EN to add a starvation guard that
// forces an IF grant after STARVE_MAX consecutive lost IF cycles.
//
// Ports
//   clk        in  1   core clock
//   rst        in  1   asynchronous active-low reset
//   if_req     in  1   IF word read request
//   if_addr    in  32  IF byte address ([1:0] ignored)
//   if_gnt     out 1   IF request accepted this cycle
//   if_rvld    out 1   if_rdata valid
//   if_rdata   out 32  fetched word (holds last value otherwise)
//   d_addr     in  32  data byte address ([1:0] ignored)
//   d_rden     in  4   data read byte enables
//   d_wren     in  4   data write byte enables (non-zero => write)
//   d_wdata    in  32  lane-aligned write data
//   d_gnt      out 1   data request accepted this cycle
//   d_rvld     out 1   d_rdata valid
//   d_rdata    out 32  raw read word (holds last value otherwise)
//   mem_en     out 1   RAM access strobe
//   mem_we     out 4   RAM byte write enables
//   mem_addr   out 32  word-aligned RAM address, 0 when idle
//   mem_wdata  out 32  RAM write data, 0 when idle
//   mem_rdata  in  32  RAM read data, valid MEM_LAT cycles after mem_en
//   hold_if    out 1   IF requested but was not granted
//   hold_ex    out 1   data requested but was not granted (guard only)
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [31:0]     if_addr,
    output logic            if_gnt,
    output logic            if_rvld,
    output logic [31:0]     if_rdata,
    input  logic [31:0]     d_addr,
    input  logic [BE_W-1:0] d_rden,
    input  logic [BE_W-1:0] d_wren,
    input  logic [31:0]     d_wdata,
    output logic            d_gnt,
    output logic            d_rvld,
    output logic [31:0]     d_rdata,
    output logic            mem_en,
    output logic [BE_W-1:0] mem_we,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    input  logic [31:0]     mem_rdata,
    output logic            hold_if,
    output logic            hold_ex
);

    if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
        $error("mem_port_arbiter: MEM_LAT must be 1..4 and STARVE_MAX 1..15");
    end

    logic        d_req;
    logic        d_is_wr;
    logic        d_win;
    logic        if_win;
    logic        pop_vld;
    logic        pop_own;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic        unused_addr_bits;

    assign unused_addr_bits = &{1'b0, if_addr[1:0], d_addr[1:0]};

    // A write takes precedence over any read enables on the same request.
    assign d_req   = (|d_rden) | (|d_wren);
    assign d_is_wr = |d_wren;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic       force_if;

    assign force_if = if_req && (starve_cnt == STARVE_LIM);
    assign d_win    = d_req & ~force_if;
    assign if_win   = if_req & ~d_win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (if_gnt) begin
            starve_cnt <= '0;
        end else if (hold_if) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign hold_ex = rst & d_req & ~d_gnt;
`else
    assign d_win   = d_req;
    assign if_win  = if_req & ~d_req;
    assign hold_ex = 1'b0;
`endif

    // Grants and holds are combinational but forced low while in reset.
    assign d_gnt   = rst & d_win;
    assign if_gnt  = rst & if_win;
    assign hold_if = rst & if_req & ~if_gnt;

    // Issue mux: the winner drives the RAM in the grant cycle; idle bus is all 0.
    always_comb begin
        mem_en    = d_gnt | if_gnt;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_addr = word_align(d_addr[31:2]);
            if (d_is_wr) begin
                mem_we    = d_wren;
                mem_wdata = d_wdata;
            end
        end else if (if_gnt) begin
            mem_addr = word_align(if_addr[31:2]);
        end
    end

    // Response stage boundary: tag pipe aligned with the RAM read latency.
    mem_resp_tag_pipe #(
        .DEPTH(MEM_LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .push_vld (if_gnt | (d_gnt & ~d_is_wr)),
        .push_own (d_gnt ? ARB_OWN_D : ARB_OWN_IF),
        .pop_vld  (pop_vld),
        .pop_own  (pop_own)
    );

    assign if_rvld = pop_vld & (pop_own == ARB_OWN_IF);
    assign d_rvld  = pop_vld & (pop_own == ARB_OWN_D);

    // Read data passes straight through in the response cycle and is kept
    // afterwards so each owner sees a stable word between responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (if_rvld) begin
                if_rdata_q <= mem_rdata;
            end
            if (d_rvld) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

    assign if_rdata = if_rvld ? mem_rdata : if_rdata_q;
    assign d_rdata  = d_rvld  ? mem_rdata : d_rdata_q;

endmodule
